// File: rtl/data_memory_pkg.sv
// Shared constants for the MEM-stage data RAM; the CPU uses the same data and address widths.
package data_memory_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int BSEL_WIDTH = DATA_WIDTH / 8;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic RST_ASSERT   = 1'b1;
  localparam logic RST_DEASSERT = 1'b0;

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane merge: selected lanes take data_i, the rest keep the stored word.
module dmem_lane_merge
  import data_memory_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic [DataWidth-1:0]   old_word,
  input  logic [DataWidth-1:0]   new_data,
  input  logic [DataWidth/8-1:0] byte_slct,
  output logic [DataWidth-1:0]   merged_word
);

  // Per-lane select between the new and the old byte.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < DataWidth / 8; i++) begin
      if (byte_slct[i] == ENABLE) begin
        merged_word[8*i +: 8] = new_data[8*i +: 8];
      end else begin
        merged_word[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM with byte-lane writes and combinational ce-gated reads.
// Optional DMEM_RESET_CLEAR_EN: clear every word while rst is high.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int MemNum    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   we,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth/8-1:0] byte_slct,
  input  logic [DataWidth-1:0]   data_i,
  output logic [DataWidth-1:0]   data_o
);

  localparam int IdxWidth = $clog2(MemNum);

  logic [DataWidth-1:0] mem_r [MemNum];
  logic [IdxWidth-1:0]  index_s;
  logic [DataWidth-1:0] old_word_s;
  logic [DataWidth-1:0] merged_s;
  logic                 write_en_s;
  logic                 unused_addr_s;

  // Byte offset and bits above the index are dropped, so addresses wrap modulo MemNum*4.
  assign index_s       = addr_i[IdxWidth+1:2];
  assign unused_addr_s = ^{addr_i[AddrWidth-1:IdxWidth+2], addr_i[1:0]};
  assign old_word_s    = mem_r[index_s];

  dmem_lane_merge #(
    .DataWidth (DataWidth)
  ) u_lane_merge (
    .old_word    (old_word_s),
    .new_data    (data_i),
    .byte_slct   (byte_slct),
    .merged_word (merged_s)
  );

  // Writes need reset released, chip enable and write enable together.
  always_comb begin
    write_en_s = DISABLE;
    if ((rst == RST_DEASSERT) && (ce == ENABLE) && (we == ENABLE)) begin
      write_en_s = ENABLE;
    end else begin
      write_en_s = DISABLE;
    end
  end

  // RAM array update.
  always_ff @(posedge clk) begin
`ifdef DMEM_RESET_CLEAR_EN
    if (rst == RST_ASSERT) begin
      for (int w = 0; w < MemNum; w++) begin
        mem_r[w] <= '0;
      end
    end else if (write_en_s == ENABLE) begin
      mem_r[index_s] <= merged_s;
    end
`else
    if (write_en_s == ENABLE) begin
      mem_r[index_s] <= merged_s;
    end
`endif
  end

  // Combinational read, forced to zero under reset or when the chip is disabled.
  always_comb begin
    data_o = '0;
    if ((rst == RST_DEASSERT) && (ce == ENABLE)) begin
      data_o = old_word_s;
    end else begin
      data_o = '0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (default build or DMEM_RESET_CLEAR_EN).
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr_i;
  logic [3:0]  byte_slct;
  logic [31:0] data_i;
  logic [31:0] data_o;

  int checks;
  int failures;

  data_memory dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .we        (we),
    .addr_i    (addr_i),
    .byte_slct (byte_slct),
    .data_i    (data_i),
    .data_o    (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    ce        = 1'b0;
    we        = 1'b0;
    addr_i    = 32'h0000_0000;
    byte_slct = 4'b0000;
    data_i    = 32'h0000_0000;
    tick();
    tick();
    check("reset_ce0", data_o, 32'h0000_0000);
    ce = 1'b1;
    #1;
    check("reset_ce1", data_o, 32'h0000_0000);

    // Full-word write then read at aliased byte offsets.
    rst = 1'b0; we = 1'b1; byte_slct = 4'b1111; addr_i = 32'h0000_0010; data_i = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    #1;
    check("full_rd_10", data_o, 32'hDEAD_BEEF);
    addr_i = 32'h0000_0011;
    #1;
    check("full_rd_11", data_o, 32'hDEAD_BEEF);
    addr_i = 32'h0000_0013;
    #1;
    check("full_rd_13", data_o, 32'hDEAD_BEEF);

    // Byte merge sequence at 0x20.
    we = 1'b1; byte_slct = 4'b1111; addr_i = 32'h0000_0020; data_i = 32'h1122_3344;
    tick();
    byte_slct = 4'b0010; data_i = 32'h0000_AA00;
    tick();
    we = 1'b0;
    #1;
    check("merge_b1", data_o, 32'h1122_AA44);
    we = 1'b1; byte_slct = 4'b1100; data_i = 32'h5566_0000;
    tick();
    we = 1'b0;
    #1;
    check("merge_b23", data_o, 32'h5566_AA44);
    we = 1'b1; byte_slct = 4'b0000; data_i = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    #1;
    check("bsel_zero", data_o, 32'h5566_AA44);

    // Enable gating of reads and writes.
    ce = 1'b0;
    #1;
    check("ce0_read", data_o, 32'h0000_0000);
    we = 1'b1; byte_slct = 4'b1111; data_i = 32'hFFFF_FFFF;
    tick();
    ce = 1'b1; we = 1'b0;
    #1;
    check("ce0_write", data_o, 32'h5566_AA44);

    // Write attempted under reset is dropped.
    rst = 1'b1;
    #1;
    check("rst_read", data_o, 32'h0000_0000);
    we = 1'b1; byte_slct = 4'b1111; addr_i = 32'h0000_0010; data_i = 32'h1234_5678;
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
`ifdef DMEM_RESET_CLEAR_EN
    check("post_rst_10", data_o, 32'h0000_0000);
    addr_i = 32'h0000_0020;
    #1;
    check("post_rst_20", data_o, 32'h0000_0000);
`else
    check("post_rst_10", data_o, 32'hDEAD_BEEF);
    addr_i = 32'h0000_0020;
    #1;
    check("post_rst_20", data_o, 32'h5566_AA44);
`endif

    // First edge after release writes normally.
    we = 1'b1; byte_slct = 4'b1111; addr_i = 32'h0000_0008; data_i = 32'h0102_0304;
    tick();
    we = 1'b0;
    #1;
    check("post_rst_wr", data_o, 32'h0102_0304);

    // Wrapped address aliases 0x8; old word visible before the edge, new after.
    we = 1'b1; addr_i = 32'h0000_1008; data_i = 32'hCAFE_F00D;
    #1;
    check("wrap_pre_edge", data_o, 32'h0102_0304);
    tick();
    check("wrap_post_edge", data_o, 32'hCAFE_F00D);
    we = 1'b0; addr_i = 32'h0000_0008;
    #1;
    check("wrap_rd_08", data_o, 32'hCAFE_F00D);
    addr_i = 32'h0000_0010;
    #1;
`ifdef DMEM_RESET_CLEAR_EN
    check("wrap_no_clobber", data_o, 32'h0000_0000);
`else
    check("wrap_no_clobber", data_o, 32'hDEAD_BEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data RAM for the pipelined MIPS CPU's MEM stage.
- Writes are synchronous with per-byte lane enables; reads are combinational, full-word, and gated by chip enable.
- Byte/halfword extraction and sign extension happen upstream in the CPU's read-mask logic, not here.
- Holds 32-bit words addressed by byte address; the two LSBs are ignored.

Parameters:
- DataWidth, 32, data word width in bits; must be a multiple of 8.
- AddrWidth, 32, width of the byte address input.
- MemNum, 1024, number of words stored; must be a power of two.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst  input  1  synchronous active-high reset.
- ce  input  1  chip/read enable; when 0, data_o reads 0.
- we  input  1  write enable, sampled on the rising clk edge.
- addr_i  input  AddrWidth  byte address.
- byte_slct  input  DataWidth/8  byte-lane write mask.
- data_i  input  DataWidth  write data, already lane-aligned.
- data_o  output  DataWidth  read data, full word.

Behaviour:
- Word index = addr_i[log2(MemNum)+1:2]. Bits [1:0] and bits above the index are ignored, so addresses wrap modulo MemNum*4.
- Read (combinational):
  - data_o = mem[index] when rst=0 and ce=1.
  - Otherwise data_o = 0.
  - No read latency; data_o follows addr_i within the same cycle.
- Write: on rising clk with rst=0, ce=1 and we=1, for each lane i with byte_slct[i]=1, mem[index][8i+7:8i] <= data_i[8i+7:8i].
- Lanes with byte_slct[i]=0 keep their old value. byte_slct=0 with we=1 writes nothing.
- Write qualification:
  - ce=0 blocks writes, even with we=1.
  - rst=1 at the edge blocks writes.
- Contents are not cleared by reset unless the optional feature is enabled. Power-up contents are unspecified (X in simulation).
- Read during write, same address: data_o shows the old word until the clock edge and the merged new word after it (write-first is not required within the cycle).
- Back-to-back writes to the same word in consecutive cycles accumulate lane by lane.
- Reset mid-operation: a write whose edge coincides with rst=1 is dropped. The next edge with rst=0 writes normally.
- No handshake, no stalls, no error outputs.

Optional Feature:
- Macro DMEM_RESET_CLEAR_EN.
- Defined: on a rising clk with rst=1, every word is set to 0 in that cycle. After reset release, all reads return 0 until written.
- Not defined: reset only forces data_o to 0 and blocks writes; stored contents survive reset.

Decomposition:
- Shared package: data width 32, address width 32, byte-select width 4, enable/disable and reset-level constants.
- These are the same constants used by the CPU (register data width, memory address width).
- One natural sub-module, dmem_lane_merge: combinational merge of the old word, data_i and byte_slct into the new word. The RAM array and enable logic stay in data_memory.

Test Plan:
- Full write/read: ce=1, we=1, byte_slct=4'b1111, addr=0x10, data_i=0xDEADBEEF, one edge; then we=0 -> data_o=0xDEADBEEF at addr 0x10, and also at 0x11 and 0x13.
- Byte merge:
  - Preload 0x11223344 at 0x20.
  - Write byte_slct=4'b0010, data_i=0x0000AA00 -> data_o=0x1122AA44.
  - Then byte_slct=4'b1100, data_i=0x55660000 -> 0x5566AA44.
- Enable gating:
  - ce=0 -> data_o=0 regardless of contents.
  - ce=0, we=1, data_i=0xFFFFFFFF at 0x20, then ce=1 -> word unchanged, 0x5566AA44.
- Reset:
  - rst=1 -> data_o=0, and a write attempt during rst is dropped.
  - After release, 0x10 still reads 0xDEADBEEF without DMEM_RESET_CLEAR_EN, or 0x00000000 with it.
- Wrap and same-cycle: write 0xCAFEF00D to addr MemNum*4+0x8 -> readable at 0x8. A read at 0x8 in the write cycle shows the old value before the edge and 0xCAFEF00D after.
